// File: rtl/envelope_scheduler.sv
// rtl/envelope_scheduler.sv - time-multiplexed per-oscillator envelope gain sequencer
// One oscillator is visited per clock through a shared add/saturate/count datapath.

`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 4
`endif

package protocol_pkg;
  typedef struct packed {
    logic signed [31:0] rate;
    logic        [31:0] duration;
  } envelope_t;

  typedef struct packed {
    envelope_t [`ENVELOPE_LEN-1:0] envelopes;
    logic      [1:0]               cmds;
  } wavegen_t;
endpackage

module envelope_scheduler #(
  parameter int N_OSC   = `N_OSCILLATORS,
  parameter int ENV_LEN = `ENVELOPE_LEN
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              sample_tick,
  input  protocol_pkg::wavegen_t [0:N_OSC-1] wave_gens,
  output logic [0:N_OSC-1][31:0]            gain,
  output logic [N_OSC-1:0]                  active,
  output logic                              gain_valid,
  output logic                              busy,
  output logic                              overrun
);

  localparam int IW = (N_OSC > 1) ? $clog2(N_OSC) : 1;
  localparam int SW = $clog2(ENV_LEN + 1);
  localparam logic [SW-1:0] DONE     = SW'(ENV_LEN);
  localparam logic [SW-1:0] LAST     = SW'(ENV_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_OSC - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          gain_valid_q, gain_valid_d;
  logic          busy_q, busy_d;

  logic [SW-1:0] stage_q [N_OSC];
  logic [SW-1:0] stage_d [N_OSC];
  logic [31:0]   rem_q   [N_OSC];
  logic [31:0]   rem_d   [N_OSC];
  logic [31:0]   gain_q  [N_OSC];
  logic [31:0]   gain_d  [N_OSC];
  logic [1:0]    prev_q  [N_OSC];
  logic [1:0]    prev_d  [N_OSC];

  protocol_pkg::wavegen_t wg;
  logic               ke, ko;
  logic [SW-1:0]      cur_stage, adv_stage, n_stage;
  logic [31:0]        cur_rem, adv_rem, n_rem;
  logic [31:0]        cur_gain, cur_rate, sat_gain, n_gain;
  logic signed [33:0] sum;

  // Shared visit datapath for the oscillator selected by idx_q.
  always_comb begin
    wg        = wave_gens[idx_q];
    cur_stage = stage_q[idx_q];
    cur_rem   = rem_q[idx_q];
    cur_gain  = gain_q[idx_q];
    ke        = wg.cmds[0] & ~prev_q[idx_q][0];
    ko        = wg.cmds[1] & ~prev_q[idx_q][1];

    cur_rate = '0;
    for (int s = 0; s < ENV_LEN; s++) begin
      if (cur_stage == SW'(s)) cur_rate = wg.envelopes[s].rate;
    end
    adv_rem = '0;
    for (int s = 0; s < ENV_LEN - 1; s++) begin
      if (cur_stage == SW'(s)) adv_rem = wg.envelopes[s+1].duration;
    end
    adv_stage = (cur_stage == LAST) ? DONE : cur_stage + SW'(1);

    sum = $signed({2'b00, cur_gain}) + $signed({{2{cur_rate[31]}}, cur_rate});
    if (sum[33])      sat_gain = 32'h0000_0000;
    else if (sum[32]) sat_gain = 32'hFFFF_FFFF;
    else              sat_gain = sum[31:0];

    n_stage = cur_stage;
    n_rem   = cur_rem;
    n_gain  = cur_gain;
    if (ke) begin
      n_gain  = '0;
      n_stage = '0;
      n_rem   = wg.envelopes[0].duration;
    end else if (ko) begin
      n_stage = LAST;
      n_rem   = wg.envelopes[ENV_LEN-1].duration;
    end else if (cur_stage == DONE) begin
      n_stage = cur_stage;
    end else if (cur_rem == '0) begin
      n_stage = adv_stage;
      n_rem   = adv_rem;
    end else begin
      n_gain = sat_gain;
      if (cur_rem == 32'd1) begin
        n_stage = adv_stage;
        n_rem   = adv_rem;
      end else begin
        n_rem = cur_rem - 32'd1;
      end
    end
  end

  always_comb begin
    stage_d = stage_q;
    rem_d   = rem_q;
    gain_d  = gain_q;
    prev_d  = prev_q;
    if (state_q == SWEEP) begin
      stage_d[idx_q] = n_stage;
      rem_d[idx_q]   = n_rem;
      gain_d[idx_q]  = n_gain;
      prev_d[idx_q]  = wg.cmds;
    end
  end

  // A tick seen while busy is parked in pending; a second one is lost.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (sample_tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (idx_q == IDX_LAST) state_d = FIN;
        else                   idx_d   = idx_q + IW'(1);
      end
      FIN: begin
        if (sample_tick && pending_q) overrun_d = 1'b1;
        pending_d = 1'b0;
        if (pending_q || sample_tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d != IDLE);
    gain_valid_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      gain_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < N_OSC; i++) begin
        stage_q[i] <= DONE;
        rem_q[i]   <= '0;
        gain_q[i]  <= '0;
        prev_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      gain_valid_q <= gain_valid_d;
      busy_q       <= busy_d;
      for (int i = 0; i < N_OSC; i++) begin
        stage_q[i] <= stage_d[i];
        rem_q[i]   <= rem_d[i];
        gain_q[i]  <= gain_d[i];
        prev_q[i]  <= prev_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_OSC; i++) begin
      gain[i]   = gain_q[i];
      active[i] = (stage_q[i] != DONE);
    end
  end

  assign gain_valid = gain_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_envelope_scheduler.sv
// tb/tb_envelope_scheduler.sv - directed bench for envelope_scheduler with a sample-level model
// Inputs change 2 time units after posedge; outputs are compared on negedge.

module tb_envelope_scheduler;
  localparam int N_OSC = 4;
  localparam int L     = 4;
  localparam longint GMAX = 64'h0000_0000_FFFF_FFFF;

  logic                              clk;
  logic                              rstn;
  logic                              sample_tick;
  protocol_pkg::wavegen_t [0:N_OSC-1] wave_gens;
  logic [0:N_OSC-1][31:0]            gain;
  logic [N_OSC-1:0]                  active;
  logic                              gain_valid;
  logic                              busy;
  logic                              overrun;

  envelope_scheduler #(.N_OSC(N_OSC), .ENV_LEN(L)) dut (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick), .wave_gens(wave_gens),
    .gain(gain), .active(active), .gain_valid(gain_valid), .busy(busy), .overrun(overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int gv_count = 0;
  bit cmp_en   = 0;

  // Model: sweep position -1 = idle, 0..N_OSC-1 = visiting that oscillator, N_OSC = finishing.
  int     m_pos;
  bit     m_pend, m_ovr;
  int     m_stage [N_OSC];
  longint m_rem   [N_OSC];
  longint m_gain  [N_OSC];
  bit [1:0] m_prev [N_OSC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic m_reset();
    m_pos = -1; m_pend = 0; m_ovr = 0;
    for (int i = 0; i < N_OSC; i++) begin
      m_stage[i] = -1; m_rem[i] = 0; m_gain[i] = 0; m_prev[i] = 2'b00;
    end
  endtask

  task automatic m_enter(input int i, input int s);
    if (s >= L) begin
      m_stage[i] = -1; m_rem[i] = 0;
    end else begin
      m_stage[i] = s; m_rem[i] = longint'(wave_gens[i].envelopes[s].duration);
    end
  endtask

  task automatic m_visit(input int i);
    bit ke, ko;
    longint g;
    ke = wave_gens[i].cmds[0] && !m_prev[i][0];
    ko = wave_gens[i].cmds[1] && !m_prev[i][1];
    if (ke) begin
      m_gain[i] = 0; m_enter(i, 0);
    end else if (ko) begin
      m_enter(i, L - 1);
    end else if (m_stage[i] < 0) begin
      m_gain[i] = m_gain[i];
    end else if (m_rem[i] == 0) begin
      m_enter(i, m_stage[i] + 1);
    end else begin
      g = m_gain[i] + longint'(wave_gens[i].envelopes[m_stage[i]].rate);
      if (g < 0) g = 0;
      if (g > GMAX) g = GMAX;
      m_gain[i] = g;
      m_rem[i]  = m_rem[i] - 1;
      if (m_rem[i] == 0) m_enter(i, m_stage[i] + 1);
    end
    m_prev[i] = wave_gens[i].cmds;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial begin
    bit tk;
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset();
      else begin
        tk = sample_tick;
        if (m_pos < 0) begin
          if (tk) m_pos = 0;
        end else if (m_pos < N_OSC) begin
          if (tk) begin
            if (m_pend) m_ovr = 1; else m_pend = 1;
          end
          m_visit(m_pos);
          m_pos++;
        end else begin
          if (tk && m_pend) m_ovr = 1;
          m_pos  = (m_pend || tk) ? 0 : -1;
          m_pend = 0;
        end
      end
    end
  end

  initial forever begin
    logic [0:N_OSC-1][31:0] eg;
    logic [N_OSC-1:0] ea;
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < N_OSC; i++) begin
        eg[i] = m_gain[i][31:0];
        ea[i] = (m_stage[i] >= 0);
      end
      check("cyc_gain", gain, eg);
      check("cyc_active", active, ea);
      check("cyc_gain_valid", gain_valid, m_pos == N_OSC);
      check("cyc_busy", busy, m_pos >= 0);
      check("cyc_overrun", overrun, m_ovr);
      if (gain_valid) gv_count++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_wait(output int lat);
    int t0;
    t0 = cyc_cnt;
    sample_tick = 1;
    cyc();
    sample_tick = 0;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (gain_valid) lat = cyc_cnt - t0;
    end
    cyc();
  endtask

  task automatic run_pattern(input logic [19:0] mask, output int gv0, output int gv1);
    gv0 = -1; gv1 = -1;
    for (int k = 0; k < 20; k++) begin
      sample_tick = mask[k];
      @(negedge clk);
      if (gain_valid) begin
        if (gv0 < 0) gv0 = k;
        else if (gv1 < 0) gv1 = k;
      end
      cyc();
    end
    sample_tick = 0;
  endtask

  task automatic set_env(input int o, input int s, input logic [31:0] r, input logic [31:0] d);
    wave_gens[o].envelopes[s].rate     = r;
    wave_gens[o].envelopes[s].duration = d;
  endtask

  logic [31:0] t2_exp [10] = '{32'h0, 32'h100, 32'h200, 32'h300, 32'h300,
                              32'h300, 32'h300, 32'h280, 32'h200, 32'h180};

  initial begin
    int lat, gv_snap, g0, g1;
    rstn = 1; sample_tick = 0; wave_gens = '0;
    #1 rstn = 0;
    #2 cmp_en = 1;
    cyc(); cyc();
    check("rst_gain", gain, '0);
    check("rst_active", active, '0);
    check("rst_flags", {gain_valid, busy, overrun}, 3'b000);
    rstn = 1;
    cyc();

    // 1: idle ticks
    gv_snap = gv_count;
    for (int k = 0; k < 3; k++) begin
      tick_wait(lat);
      check("t1_latency", lat, N_OSC + 1);
      repeat (2) cyc();
    end
    check("t1_pulses", gv_count - gv_snap, 3);
    check("t1_gain", gain, '0);
    check("t1_active", active, '0);

    // 2: attack / sustain / empty stage / release on osc0
    set_env(0, 0, 32'h100, 3);
    set_env(0, 1, 32'h0, 2);
    set_env(0, 2, 32'h0, 0);
    set_env(0, 3, 32'hFFFF_FF80, 4);
    wave_gens[0].cmds = 2'b01;
    for (int k = 0; k < 10; k++) begin
      tick_wait(lat);
      check("t2_gain0", gain[0], t2_exp[k]);
      check("t2_model0", m_gain[0], t2_exp[k]);
      check("t2_active0", active[0], 1'b1);
    end
    tick_wait(lat);
    check("t2_final_gain0", gain[0], 32'h100);
    check("t2_final_active0", active[0], 1'b0);

    // 3: saturation on osc1
    set_env(1, 0, 32'h10, 1);
    set_env(1, 1, 32'h8000_0000, 1);
    set_env(1, 2, 32'h7FFF_FFFF, 3);
    set_env(1, 3, 32'h0, 0);
    wave_gens[1].cmds = 2'b01;
    tick_wait(lat);
    tick_wait(lat);
    check("t3_gain_pre", gain[1], 32'h10);
    tick_wait(lat);
    check("t3_neg_clamp", gain[1], 32'h0);
    tick_wait(lat);
    tick_wait(lat);
    check("t3_mid", gain[1], 32'hFFFF_FFFE);
    tick_wait(lat);
    check("t3_pos_clamp", gain[1], 32'hFFFF_FFFF);
    check("t3_model_clamp", m_gain[1], 32'hFFFF_FFFF);

    // 4: key-off on osc2, simultaneous key-on/key-off on osc3
    set_env(2, 0, 32'h100, 10);
    set_env(2, 3, 32'hFFFF_FF00, 8);
    set_env(3, 0, 32'h40, 20);
    set_env(3, 3, 32'hFFFF_FFF0, 8);
    wave_gens[2].cmds = 2'b01;
    wave_gens[3].cmds = 2'b01;
    for (int k = 0; k < 6; k++) tick_wait(lat);
    check("t4_osc2_attack", gain[2], 32'h500);
    check("t4_osc3_attack", gain[3], 32'h140);
    wave_gens[2].cmds = 2'b11;
    wave_gens[3].cmds = 2'b00;
    tick_wait(lat);
    check("t4_ko_hold", gain[2], 32'h500);
    check("t4_ko_active", active[2], 1'b1);
    check("t4_osc3_run", gain[3], 32'h180);
    wave_gens[3].cmds = 2'b11;
    tick_wait(lat);
    check("t4_release", gain[2], 32'h400);
    check("t4_keon_wins", gain[3], 32'h0);
    check("t4_keon_active", active[3], 1'b1);
    tick_wait(lat);
    check("t4_stage0_rate", gain[3], 32'h40);

    // 5: pending tick and overrun
    run_pattern(20'b0000_0000_0000_0000_0101, g0, g1);
    check("t5_fin1", g0, N_OSC + 1);
    check("t5_fin2", g1, 2 * (N_OSC + 1));
    check("t5_no_overrun", overrun, 1'b0);
    run_pattern(20'b0000_0000_0000_0000_1101, g0, g1);
    check("t5_b_fin2", g1, 2 * (N_OSC + 1));
    check("t5_overrun", overrun, 1'b1);
    repeat (5) cyc();
    check("t5_overrun_sticky", overrun, 1'b1);

    // 6: reset at idx 2 of a sweep
    sample_tick = 1;
    cyc();
    sample_tick = 0;
    cyc();
    cyc();
    rstn = 0;
    #1;
    check("t6_gain", gain, '0);
    check("t6_active", active, '0);
    check("t6_flags", {gain_valid, busy, overrun}, 3'b000);
    gv_snap = gv_count;
    cyc(); cyc();
    rstn = 1;
    repeat (10) cyc();
    check("t6_no_pulse", gv_count - gv_snap, 0);
    check("t6_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
